// File: rtl/core_pkg.sv
// core_pkg: shared ALU op encodings, control bundle and bubble constant for the RV32I pipeline
package core_pkg;

    localparam logic [1:0] ALUOP_ITYPE = 2'b00;
    localparam logic [1:0] ALUOP_BTYPE = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use detection between the load in EX and the instruction in ID
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    output logic       load_use
);

    assign load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                      ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX stage register with load-use stall, hold, flush and saturating perf counters
module id_ex_pipeline_reg
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [1:0]       id_alu_op,
    input  logic [2:0]       id_funct3,
    input  logic [6:0]       id_funct7,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs2,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_alu_src,
    input  logic             id_branch,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             ex_valid,
    output logic [1:0]       ex_alu_op,
    output logic [2:0]       ex_funct3,
    output logic [6:0]       ex_funct7,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic  load_use;
    logic  bubble;
    logic  load;
    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;

    hazard_detect u_hazard (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .load_use    (load_use)
    );

    assign stall_o = load_use | hold_i;
    // flush beats hold; load_use only acts when the stage is not frozen
    assign load    = flush_i | ~hold_i;
    assign bubble  = flush_i | load_use;
    // an invalid decode slot must never carry live control into EX
    assign id_ctrl = id_valid ? ctrl_t'{reg_write: id_reg_write, mem_read: id_mem_read,
                                        mem_write: id_mem_write, mem_to_reg: id_mem_to_reg,
                                        alu_src: id_alu_src, branch: id_branch} : BUBBLE;
    assign {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch} = ex_ctrl;

    // Stage register: bubble on flush or load-use, freeze on hold, otherwise capture decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_alu_op   <= ALUOP_ITYPE;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= BUBBLE;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
        end else if (load) begin
            ex_valid    <= id_valid & ~bubble;
            ex_alu_op   <= bubble ? ALUOP_ITYPE : id_alu_op;
            ex_funct3   <= bubble ? '0 : id_funct3;
            ex_funct7   <= bubble ? '0 : id_funct7;
            ex_rs1      <= bubble ? '0 : id_rs1;
            ex_rs2      <= bubble ? '0 : id_rs2;
            ex_rd       <= bubble ? '0 : id_rd;
            ex_ctrl     <= bubble ? BUBBLE : id_ctrl;
            ex_rs1_data <= bubble ? '0 : id_rs1_data;
            ex_rs2_data <= bubble ? '0 : id_rs2_data;
            ex_imm      <= bubble ? '0 : id_imm;
            ex_pc       <= bubble ? '0 : id_pc;
        end
    end

    // Saturating debug counters: flushes always count, load-use bubbles only when actually inserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (flush_i && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (!flush_i && !hold_i && load_use && !(&bubble_cnt))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb_id_ex_pipeline_reg: randomized and directed checks of the ID/EX register against a behavioural model
module tb_id_ex_pipeline_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [1:0]  id_alu_op = '0;
    logic [2:0]  id_funct3 = '0;
    logic [6:0]  id_funct7 = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_uses_rs2 = 1'b0;
    logic [5:0]  id_c = '0;
    logic [31:0] id_rs1_data = '0, id_rs2_data = '0, id_imm = '0, id_pc = '0;
    logic        hold_i = 1'b0, flush_i = 1'b0;

    logic        stall_o, ex_valid;
    logic [1:0]  ex_alu_op;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [15:0] bubble_cnt, flush_cnt;

    logic        s_stall, s_valid;
    logic [1:0]  s_alu_op;
    logic [2:0]  s_funct3;
    logic [6:0]  s_funct7;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic        s_rw, s_mr, s_mw, s_m2r, s_as, s_br;
    logic [31:0] s_d1, s_d2, s_im, s_pc;
    logic [3:0]  s_bubble_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    logic        m_v;
    logic [1:0]  m_op;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [5:0]  m_c;
    logic [31:0] m_d1, m_d2, m_im, m_pc;
    int          n_bub, n_fl;

    always #5 clk = ~clk;

    id_ex_pipeline_reg dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_uses_rs2(id_uses_rs2), .id_reg_write(id_c[5]), .id_mem_read(id_c[4]),
        .id_mem_write(id_c[3]), .id_mem_to_reg(id_c[2]), .id_alu_src(id_c[1]), .id_branch(id_c[0]),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .hold_i(hold_i), .flush_i(flush_i), .stall_o(stall_o), .ex_valid(ex_valid),
        .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
        .ex_branch(ex_branch), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_pipeline_reg #(.XLEN(32), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_uses_rs2(id_uses_rs2), .id_reg_write(id_c[5]), .id_mem_read(id_c[4]),
        .id_mem_write(id_c[3]), .id_mem_to_reg(id_c[2]), .id_alu_src(id_c[1]), .id_branch(id_c[0]),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .hold_i(hold_i), .flush_i(flush_i), .stall_o(s_stall), .ex_valid(s_valid),
        .ex_alu_op(s_alu_op), .ex_funct3(s_funct3), .ex_funct7(s_funct7), .ex_rs1(s_rs1),
        .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_reg_write(s_rw), .ex_mem_read(s_mr),
        .ex_mem_write(s_mw), .ex_mem_to_reg(s_m2r), .ex_alu_src(s_as),
        .ex_branch(s_br), .ex_rs1_data(s_d1), .ex_rs2_data(s_d2),
        .ex_imm(s_im), .ex_pc(s_pc), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    function automatic logic model_load_use();
        return m_v && m_c[4] && m_rd != 0 && id_valid &&
               (m_rd == id_rs1 || (id_uses_rs2 && m_rd == id_rs2));
    endfunction

    task automatic model_clear();
        {m_v, m_op, m_f3, m_f7, m_rs1, m_rs2, m_rd, m_c, m_d1, m_d2, m_im, m_pc} = '0;
    endtask

    task automatic check_all();
        chk("valid", ex_valid, m_v);
        chk("op_funct", {ex_alu_op, ex_funct3, ex_funct7}, {m_op, m_f3, m_f7});
        chk("regidx", {ex_rs1, ex_rs2, ex_rd}, {m_rs1, m_rs2, m_rd});
        chk("ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch}, m_c);
        chk("operands", {ex_rs1_data, ex_rs2_data}, {m_d1, m_d2});
        chk("imm_pc", {ex_imm, ex_pc}, {m_im, m_pc});
        chk("bubble_cnt", bubble_cnt, sat(n_bub, 16'hFFFF));
        chk("flush_cnt", flush_cnt, sat(n_fl, 16'hFFFF));
        chk("bubble_cnt4", s_bubble_cnt, sat(n_bub, 15));
        chk("flush_cnt4", s_flush_cnt, sat(n_fl, 15));
    endtask

    // one clock: check comb stall, advance the model with the spec's priority rules, check EX
    task automatic step();
        logic lu;
        #1;
        lu = model_load_use();
        chk("stall_o", stall_o, lu | hold_i);
        @(posedge clk);
        if (flush_i) begin
            model_clear();
            n_fl++;
        end else if (hold_i) begin
        end else if (lu) begin
            model_clear();
            n_bub++;
        end else begin
            m_v = id_valid; m_op = id_alu_op; m_f3 = id_funct3; m_f7 = id_funct7;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_c = id_valid ? id_c : 6'd0;
            m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_im = id_imm; m_pc = id_pc;
        end
        #1;
        check_all();
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic u2, input logic [5:0] c);
        id_valid = 1'b1; id_alu_op = op; id_funct3 = 3'd0; id_funct7 = 7'd0;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_uses_rs2 = u2; id_c = c;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
        hold_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic randomize_inputs();
        id_valid = $urandom_range(0, 9) != 0;
        id_alu_op = 2'($urandom_range(0, 2));
        id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3)); id_uses_rs2 = 1'($urandom);
        id_c = 6'($urandom);
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
        hold_i = $urandom_range(0, 6) == 0;
        flush_i = $urandom_range(0, 9) == 0;
    endtask

    initial begin
        logic [4:0]  h_rd;
        logic [31:0] h_pc;
        model_clear();
        n_bub = 0; n_fl = 0;
        #12;
        check_all();
        rst_n = 1'b1;
        // R-type add x3,x1,x2
        set_instr(2'b10, 5'd1, 5'd2, 5'd3, 1'b1, 6'b100000);
        step();
        chk("rtype_op", ex_alu_op, 2'b10);
        chk("rtype_rd", ex_rd, 5'd3);
        chk("rtype_valid", ex_valid, 1'b1);
        // lw x5 then add x6,x5,x7
        set_instr(2'b00, 5'd1, 5'd0, 5'd5, 1'b0, 6'b110110);
        step();
        set_instr(2'b10, 5'd5, 5'd7, 5'd6, 1'b1, 6'b100000);
        #1 chk("lu_stall", stall_o, 1'b1);
        step();
        chk("lu_bubble", ex_valid, 1'b0);
        chk("lu_cnt", bubble_cnt, 16'd1);
        step();
        chk("lu_replay_rd", ex_rd, 5'd6);
        // lw x0 with ID reading x0
        set_instr(2'b00, 5'd1, 5'd0, 5'd0, 1'b0, 6'b110110);
        step();
        set_instr(2'b10, 5'd0, 5'd0, 5'd6, 1'b1, 6'b100000);
        #1 chk("x0_stall", stall_o, 1'b0);
        step();
        // lw x5 with addi x6,x0 whose rs2 field happens to be 5
        set_instr(2'b00, 5'd1, 5'd0, 5'd5, 1'b0, 6'b110110);
        step();
        set_instr(2'b00, 5'd0, 5'd5, 5'd6, 1'b0, 6'b100010);
        #1 chk("rs2_filter_stall", stall_o, 1'b0);
        step();
        // flush with hold and a valid ID instruction
        set_instr(2'b10, 5'd1, 5'd2, 5'd9, 1'b1, 6'b100000);
        hold_i = 1'b1; flush_i = 1'b1;
        step();
        chk("flush_valid", ex_valid, 1'b0);
        chk("flush_cnt1", flush_cnt, 16'd1);
        chk("flush_bub", bubble_cnt, 16'd1);
        // hold for 3 cycles
        set_instr(2'b01, 5'd2, 5'd3, 5'd11, 1'b1, 6'b000001);
        step();
        h_rd = ex_rd; h_pc = ex_pc;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            hold_i = 1'b1; flush_i = 1'b0;
            step();
            chk("hold_rd", ex_rd, 5'd11);
            chk("hold_pc", ex_pc, id_pc == h_pc ? h_pc : h_pc);
        end
        chk("hold_rd_stable", ex_rd, h_rd);
        // saturate the 4-bit counter with repeated load-use
        for (int i = 0; i < 20; i++) begin
            set_instr(2'b00, 5'd1, 5'd0, 5'd5, 1'b0, 6'b110110);
            step();
            set_instr(2'b10, 5'd5, 5'd7, 5'd6, 1'b1, 6'b100000);
            step();
        end
        chk("sat_bub4", s_bubble_cnt, 4'hF);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end
        // asynchronous reset mid-run with a valid instruction in EX
        set_instr(2'b10, 5'd1, 5'd2, 5'd3, 1'b1, 6'b100000);
        step();
        chk("pre_reset_valid", ex_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        n_bub = 0; n_fl = 0;
        check_all();
        #1 rst_n = 1'b1;
        randomize_inputs();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
- ID/EX pipeline register of the pipelined RV32I core, sitting directly upstream of the ALU control unit and ALU.
- Latches decoded control (ALU_Op, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch), instruction fields (funct3, funct7, rs1, rs2, rd) and operands (rs1/rs2 data, immediate, PC) from decode.
- Integrates load-use hazard detection, bubble insertion, hold and flush.
- Keeps a saturating stall/bubble counter for performance debug.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- CNT_W, 16, width of each saturating performance counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  decode stage holds a real instruction.
- id_alu_op  input  2  00 = I/load/store add, 01 = branch sub, 10 = R-type.
- id_funct3  input  3  instruction funct3.
- id_funct7  input  7  instruction funct7.
- id_rs1, id_rs2, id_rd  input  5 each  register indices.
- id_uses_rs2  input  1  instruction reads rs2 (R, S and B types).
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch  input  1 each  decoded control bits.
- id_rs1_data, id_rs2_data, id_imm, id_pc  input  XLEN each  operands.
- hold_i  input  1  downstream stall: freeze EX contents.
- flush_i  input  1  taken branch resolved in EX: kill the instruction entering EX.
- stall_o  output  1  combinational; freezes PC and IF/ID.
- ex_valid  output  1  EX contains a real instruction.
- ex_alu_op, ex_funct3, ex_funct7, ex_rs1, ex_rs2, ex_rd, ex_* control and data  output  registered copies of the id_* inputs, same widths.
- bubble_cnt  output  CNT_W  count of bubbles inserted by load-use detection.
- flush_cnt  output  CNT_W  count of flushes applied.

Behaviour:
- Reset (asynchronous, rst_n=0): every ex_* output is 0, ex_valid=0, both counters 0. ex_alu_op=00 makes the EX-stage ALU op ADD, which is harmless. Reset mid-operation discards the EX contents immediately, without waiting for a clock edge.
- load_use = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (id_uses_rs2 & (ex_rd==id_rs2))).
- stall_o = load_use | hold_i. Purely combinational, no flop in the path.
- Per-edge update, in priority order:
  1. flush_i=1: load a bubble (ex_valid=0, all control bits 0, ex_alu_op=00, data/index fields 0). flush_cnt+1. Flush overrides hold_i and load_use.
  2. hold_i=1: all ex_* registers keep their value. No counter change.
  3. load_use=1: load a bubble. bubble_cnt+1. The ID instruction is retained upstream by stall_o and re-presented next cycle. Load-use therefore costs exactly 1 bubble cycle.
  4. Otherwise: capture all id_* inputs. ex_valid=id_valid.
- id_valid=0 with no other event: ex_valid=0 and the control bits are forced to 0, so no stray RegWrite or MemWrite reaches EX.
- rd/rs index 0: never triggers load_use (x0 is hard-wired).
- Counters saturate at all-ones and never wrap.
- Simultaneous flush_i and load_use: flush wins, only flush_cnt increments. stall_o is still asserted that cycle; IF/ID is flushed upstream by the same flush_i.
- Latency: ID to EX in 1 cycle. No combinational path from id_* data to ex_* outputs.

Decomposition:
- Shared package core_pkg:
  - ALU_Op encodings (ALUOP_ITYPE=2'b00, ALUOP_BTYPE=2'b01, ALUOP_RTYPE=2'b10).
  - A packed ctrl_t struct of the six control bits.
  - A BUBBLE constant (all zero).
- Sub-module hazard_detect: purely combinational load_use computation, reusable by a later forwarding unit.

Test Plan:
- Reset: drive rst_n=0 mid-run with ex_valid=1 → all ex_* outputs, ex_valid, bubble_cnt and flush_cnt read 0 before the next clk edge.
- Normal flow: R-type add x3,x1,x2 (alu_op=10, funct3=000, funct7=0) → next cycle ex_alu_op=10, ex_rd=3, ex_valid=1, stall_o=0.
- Load-use: lw x5 in EX (ex_mem_read=1, ex_rd=5), ID add x6,x5,x7 → stall_o=1 that cycle; next cycle ex_valid=0 and bubble_cnt=1; following cycle ex_rd=6.
- x0 and rs2 filter:
  - lw x0 in EX with ID reading x0 → stall_o=0.
  - lw x5 in EX with ID addi x6,x0,imm (id_rs2 field=5, id_uses_rs2=0) → stall_o=0.
- Flush with hold: flush_i=1 and hold_i=1 with a valid ID instruction → EX becomes bubble, flush_cnt=1, bubble_cnt unchanged.
- Hold and saturation:
  - hold_i=1 for 3 cycles → ex_* stable and equal to pre-hold values.
  - Force bubble_cnt to 0xFFFF, then another load-use → bubble_cnt stays 0xFFFF.
